// File: rtl/adder_tree_mac.sv
// Pipelined M x M multiply-accumulate: registered partial products feed a registered
// binary adder tree, and the final stage accumulates into the output register.
module adder_tree_mac #(
    parameter int M     = 8,
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [M-1:0]     in_a,
    input  logic [M-1:0]     in_b,
    input  logic             in_signed,
    input  logic             in_first,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*M-1:0]   out_prod,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf
);
    localparam int N      = 2 * M;
    localparam int LEVELS = $clog2(M);

    logic             advance;
    logic [N-1:0]     a_ext;
    logic [N-1:0]     pp [M];

    // Level 0 holds the partial products; level l holds M>>l running sums.
    logic [N-1:0]     tree_reg [LEVELS+1][M];
    logic [LEVELS:0]  vld_reg;
    logic [LEVELS:0]  sgn_reg;
    logic [LEVELS:0]  first_reg;

    logic [N-1:0]     root;
    logic [ACC_W-1:0] p_ext;
    logic [ACC_W-1:0] acc_base;
    logic [ACC_W:0]   acc_sum;
    logic             ovf_next;

    // The whole pipe freezes while the output beat is held back.
    assign advance  = !(out_valid && !out_ready);
    assign in_ready = advance;

    assign a_ext = in_signed ? N'($signed(in_a)) : N'(in_a);

    // Sign-extended partial products; in signed mode the multiplier MSB carries
    // negative weight, so its row is subtracted instead of added.
    genvar gi;
    generate
        for (gi = 0; gi < M; gi++) begin : g_pp
            logic [N-1:0] shifted;
            assign shifted = a_ext << gi;
            if (gi == M - 1) begin : g_msb
                assign pp[gi] = !in_b[gi] ? '0 : (in_signed ? N'(0) - shifted : shifted);
            end else begin : g_low
                assign pp[gi] = in_b[gi] ? shifted : '0;
            end
        end
    endgenerate

    assign root = tree_reg[LEVELS][0];

    always_comb begin
        p_ext    = sgn_reg[LEVELS] ? ACC_W'($signed(root)) : ACC_W'(root);
        acc_base = first_reg[LEVELS] ? '0 : out_acc;
        acc_sum  = {1'b0, acc_base} + {1'b0, p_ext};
        ovf_next = 1'b0;
        if (!first_reg[LEVELS]) begin
            if (sgn_reg[LEVELS]) begin
                ovf_next = (acc_base[ACC_W-1] == p_ext[ACC_W-1]) &&
                           (acc_sum[ACC_W-1] != acc_base[ACC_W-1]);
            end else begin
                ovf_next = acc_sum[ACC_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l <= LEVELS; l++) begin
                for (int j = 0; j < M; j++) begin
                    tree_reg[l][j] <= '0;
                end
            end
            vld_reg   <= '0;
            sgn_reg   <= '0;
            first_reg <= '0;
            out_valid <= 1'b0;
            out_prod  <= '0;
            out_acc   <= '0;
            out_ovf   <= 1'b0;
        end else if (advance) begin
            for (int j = 0; j < M; j++) begin
                tree_reg[0][j] <= pp[j];
            end
            for (int l = 1; l <= LEVELS; l++) begin
                for (int j = 0; j < (M >> l); j++) begin
                    tree_reg[l][j] <= tree_reg[l-1][2*j] + tree_reg[l-1][2*j+1];
                end
            end
            vld_reg   <= {vld_reg[LEVELS-1:0], in_valid};
            sgn_reg   <= {sgn_reg[LEVELS-1:0], in_signed};
            first_reg <= {first_reg[LEVELS-1:0], in_first};
            out_valid <= vld_reg[LEVELS];
            if (vld_reg[LEVELS]) begin
                out_prod <= root;
                out_acc  <= acc_sum[ACC_W-1:0];
                out_ovf  <= ovf_next;
            end
        end
    end
endmodule
